// File: rtl/debug_cmd_ctrl.sv
// Debug command sequencer between the MicroBlaze control-frame link and the MIPS pipeline.
// Optional build macro CYCLE_COUNT_EN adds a 32-bit pipeline cycle counter.
module debug_cmd_ctrl #(
  parameter int unsigned NB_CONTROL_FRAME = 32,
  parameter int unsigned NB_INSTR_ADDR    = 9,
  parameter int unsigned NB_ADDR_DATA     = 16,
  parameter int unsigned NB_SEL           = 6,
  parameter int unsigned RD_TIMEOUT       = 15
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
  output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
  output logic                        o_frame_valid,
  output logic                        o_pipe_enable,
  output logic                        o_pipe_reset,
  input  logic                        i_halt,
  output logic                        o_instr_we,
  output logic [NB_INSTR_ADDR-1:0]    o_instr_addr,
  output logic [NB_CONTROL_FRAME-1:0] o_instr_data,
  output logic                        o_rd_req,
  output logic [NB_SEL-1:0]           o_rd_sel,
  output logic [NB_ADDR_DATA-1:0]     o_rd_addr,
  input  logic [NB_CONTROL_FRAME-1:0] i_rd_data,
  input  logic                        i_rd_valid
);

  localparam int unsigned TMO_W = $clog2(RD_TIMEOUT + 1);

  localparam logic [5:0] CodeStart    = 6'b000001;
  localparam logic [5:0] CodeReset    = 6'b000010;
  localparam logic [5:0] CodeReqData  = 6'b000011;
  localparam logic [5:0] CodeLoadLsb  = 6'b000100;
  localparam logic [5:0] CodeLoadMsb  = 6'b000101;
  localparam logic [5:0] CodeModeGet  = 6'b001000;
  localparam logic [5:0] CodeModeCont = 6'b001001;
  localparam logic [5:0] CodeModeStep = 6'b001010;
  localparam logic [5:0] CodeStep     = 6'b100000;
  localparam logic [5:0] CodeGotData  = 6'b100100;
  localparam logic [5:0] CodeGibData  = 6'b100101;

  typedef enum logic [2:0] {
    StIdle, StRun, StStepWait, StHalted, StRdReq, StRdWait, StRdPresent, StRdAcked
  } state_e;

  state_e                      r_state, w_state_nxt, r_origin, w_origin_nxt, w_eff_state;
  logic                        r_mode, w_mode_nxt, r_err, w_err_nxt;
  logic [5:0]                  r_last_code, w_last_code_nxt;
  logic [15:0]                 r_step_cnt, w_step_cnt_nxt;
  logic                        r_step_pulse, w_step_pulse_nxt;
  logic                        r_valid_prev, r_pipe_reset, w_pipe_reset_nxt;
  logic [NB_ADDR_DATA-1:0]     r_lsb, w_lsb_nxt;
  logic                        r_instr_we, w_instr_we_nxt;
  logic [NB_INSTR_ADDR-1:0]    r_instr_addr, w_instr_addr_nxt;
  logic [NB_CONTROL_FRAME-1:0] r_instr_data, w_instr_data_nxt;
  logic [NB_SEL-1:0]           r_sel, w_sel_nxt;
  logic [1:0]                  r_words, w_words_nxt, r_index, w_index_nxt;
  logic                        r_latch, w_latch_nxt;
  logic [NB_ADDR_DATA-1:0]     r_base_addr, w_base_addr_nxt;
  logic [NB_CONTROL_FRAME-1:0] r_word, w_word_nxt;
  logic [TMO_W-1:0]            r_tmo, w_tmo_nxt;

  logic                        w_accept, w_legal, w_clr_cnt, w_pipe_en, w_running;
  logic [5:0]                  w_code;
  logic [NB_INSTR_ADDR-1:0]    w_atype;
  logic [NB_ADDR_DATA-1:0]     w_addr;
  logic [15:0]                 w_cnt16;
  logic [NB_CONTROL_FRAME-1:0] w_status;
  logic                        w_map_ok, w_map_latch;
  logic [NB_SEL-1:0]           w_map_sel;
  logic [1:0]                  w_map_words;

  assign w_code   = i_frame_from_blaze[31:26];
  assign w_atype  = i_frame_from_blaze[24:16];
  assign w_addr   = i_frame_from_blaze[15:0];
  assign w_accept = i_frame_from_blaze[25] & ~r_valid_prev;

  // A non-GIB command in RD_ACKED closes the readout and is judged against the origin state.
  assign w_eff_state = (r_state == StRdAcked && w_code != CodeGibData) ? r_origin : r_state;

`ifdef CYCLE_COUNT_EN
  logic [31:0] r_cycle_cnt;
  logic        w_map_cyc;
  assign w_cnt16 = r_cycle_cnt[15:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)       r_cycle_cnt <= '0;
    else if (w_clr_cnt) r_cycle_cnt <= '0;
    else if (w_pipe_en) r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end
`else
  assign w_cnt16 = r_step_cnt;
`endif

  always_comb begin
    w_map_ok    = 1'b1;
    w_map_sel   = '0;
    w_map_words = 2'd1;
    w_map_latch = 1'b1;
`ifdef CYCLE_COUNT_EN
    w_map_cyc   = 1'b0;
`endif
    case (w_atype)
      9'h001: begin w_map_sel = 6'b100000; w_map_latch = 1'b0; end
      9'h002: begin w_map_sel = 6'b100001; w_map_latch = 1'b0; end
      9'h004: begin w_map_sel = 6'b000000; w_map_latch = 1'b0; end
      9'h005: begin w_map_sel = 6'b000001; w_map_latch = 1'b0; end
      9'h008: w_map_sel = 6'b100100;
      9'h009: begin w_map_sel = 6'b100101; w_map_words = 2'd2; end
      9'h010: begin w_map_sel = 6'b100110; w_map_words = 2'd3; end
      9'h011: begin w_map_sel = 6'b100111; w_map_words = 2'd2; end
      9'h020: begin w_map_sel = 6'b101000; w_map_words = 2'd2; end
      9'h021: begin w_map_sel = 6'b101001; w_map_words = 2'd2; end
      9'h040: begin w_map_sel = 6'b101010; w_map_words = 2'd2; end
      9'h041: begin w_map_sel = 6'b101011; w_map_words = 2'd2; end
`ifdef CYCLE_COUNT_EN
      9'h006: begin w_map_cyc = 1'b1; w_map_latch = 1'b0; end
`endif
      default: w_map_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_origin_nxt     = r_origin;
    w_mode_nxt       = r_mode;
    w_err_nxt        = r_err;
    w_last_code_nxt  = r_last_code;
    w_step_cnt_nxt   = r_step_cnt;
    w_step_pulse_nxt = 1'b0;
    w_pipe_reset_nxt = 1'b0;
    w_lsb_nxt        = r_lsb;
    w_instr_we_nxt   = 1'b0;
    w_instr_addr_nxt = r_instr_addr;
    w_instr_data_nxt = r_instr_data;
    w_sel_nxt        = r_sel;
    w_words_nxt      = r_words;
    w_index_nxt      = r_index;
    w_latch_nxt      = r_latch;
    w_base_addr_nxt  = r_base_addr;
    w_word_nxt       = r_word;
    w_tmo_nxt        = r_tmo;
    w_clr_cnt        = 1'b0;
    w_legal          = 1'b0;

    unique case (r_state)
      StRun, StStepWait: if (i_halt) w_state_nxt = StHalted;
      StRdReq: begin
        w_state_nxt = StRdWait;
        w_tmo_nxt   = '0;
      end
      StRdWait: begin
        if (i_rd_valid) begin
          w_word_nxt  = i_rd_data;
          w_state_nxt = StRdPresent;
        end else if (r_tmo == TMO_W'(RD_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = r_origin;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      default: ;
    endcase

    if (w_accept) begin
      w_last_code_nxt = w_code;
      case (w_code)
        CodeReset, CodeModeGet:     w_legal = 1'b1;
        CodeStart, CodeLoadLsb,
        CodeLoadMsb:                w_legal = (w_eff_state == StIdle);
        CodeReqData:                w_legal = w_map_ok &&
                                              (w_eff_state inside {StIdle, StStepWait, StHalted});
        CodeModeCont, CodeModeStep: w_legal = (w_eff_state inside {StIdle, StHalted});
        CodeStep:                   w_legal = (w_eff_state == StStepWait);
        CodeGotData:                w_legal = (r_state == StRdPresent);
        CodeGibData:                w_legal = (r_state == StRdAcked);
        default:                    w_legal = 1'b0;
      endcase

      if (!w_legal) begin
        w_err_nxt = 1'b1;
      end else begin
        if (r_state == StRdAcked && w_code != CodeGibData) w_state_nxt = r_origin;
        case (w_code)
          CodeReset: begin
            w_state_nxt      = StIdle;
            w_pipe_reset_nxt = 1'b1;
            w_err_nxt        = 1'b0;
            w_step_cnt_nxt   = '0;
            w_clr_cnt        = 1'b1;
          end
          CodeStart:    w_state_nxt = r_mode ? StStepWait : StRun;
          CodeModeCont: w_mode_nxt = 1'b0;
          CodeModeStep: w_mode_nxt = 1'b1;
          CodeStep: begin
            w_step_pulse_nxt = 1'b1;
            w_step_cnt_nxt   = r_step_cnt + 16'd1;
          end
          CodeLoadLsb: w_lsb_nxt = w_addr;
          CodeLoadMsb: begin
            w_instr_we_nxt   = 1'b1;
            w_instr_addr_nxt = w_atype;
            w_instr_data_nxt = {w_addr, r_lsb};
          end
          CodeReqData: begin
            w_origin_nxt    = w_eff_state;
            w_sel_nxt       = w_map_sel;
            w_words_nxt     = w_map_words;
            w_latch_nxt     = w_map_latch;
            w_base_addr_nxt = w_addr;
            w_index_nxt     = '0;
            w_state_nxt     = StRdReq;
`ifdef CYCLE_COUNT_EN
            if (w_map_cyc) begin
              w_word_nxt  = r_cycle_cnt;
              w_state_nxt = StRdPresent;
            end
`endif
          end
          CodeGotData: w_state_nxt = StRdAcked;
          CodeGibData: begin
            if ({1'b0, r_index} + 3'd1 < {1'b0, r_words}) begin
              w_index_nxt = r_index + 2'd1;
              w_state_nxt = StRdReq;
            end else begin
              w_err_nxt   = 1'b1;
              w_state_nxt = r_origin;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_origin     <= StIdle;
      r_mode       <= 1'b0;
      r_err        <= 1'b0;
      r_last_code  <= '0;
      r_step_cnt   <= '0;
      r_step_pulse <= 1'b0;
      r_valid_prev <= 1'b0;
      r_pipe_reset <= 1'b0;
      r_lsb        <= '0;
      r_instr_we   <= 1'b0;
      r_instr_addr <= '0;
      r_instr_data <= '0;
      r_sel        <= '0;
      r_words      <= '0;
      r_index      <= '0;
      r_latch      <= 1'b0;
      r_base_addr  <= '0;
      r_word       <= '0;
      r_tmo        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_origin     <= w_origin_nxt;
      r_mode       <= w_mode_nxt;
      r_err        <= w_err_nxt;
      r_last_code  <= w_last_code_nxt;
      r_step_cnt   <= w_step_cnt_nxt;
      r_step_pulse <= w_step_pulse_nxt;
      r_valid_prev <= i_frame_from_blaze[25];
      r_pipe_reset <= w_pipe_reset_nxt;
      r_lsb        <= w_lsb_nxt;
      r_instr_we   <= w_instr_we_nxt;
      r_instr_addr <= w_instr_addr_nxt;
      r_instr_data <= w_instr_data_nxt;
      r_sel        <= w_sel_nxt;
      r_words      <= w_words_nxt;
      r_index      <= w_index_nxt;
      r_latch      <= w_latch_nxt;
      r_base_addr  <= w_base_addr_nxt;
      r_word       <= w_word_nxt;
      r_tmo        <= w_tmo_nxt;
    end
  end

  assign w_pipe_en = (r_state == StRun) | r_step_pulse;
  assign w_running = (r_state == StRun) | (r_state == StStepWait);
  assign w_status  = {r_last_code, r_err, (r_state == StHalted), w_running, r_mode, 6'b0, w_cnt16};

  assign o_frame_valid    = (r_state == StRdPresent);
  assign o_frame_to_blaze = o_frame_valid ? r_word : w_status;
  assign o_pipe_enable    = w_pipe_en;
  assign o_pipe_reset     = r_pipe_reset;
  assign o_instr_we       = r_instr_we;
  assign o_instr_addr     = r_instr_addr;
  assign o_instr_data     = r_instr_data;
  assign o_rd_req         = (r_state == StRdReq);
  assign o_rd_sel         = r_sel;
  assign o_rd_addr        = r_latch ? {{(NB_ADDR_DATA - 2){1'b0}}, r_index} : r_base_addr;

endmodule

// File: tb/tb_debug_cmd_ctrl.sv
// Directed bench for debug_cmd_ctrl: table of command frames with expected status words,
// plus hand-written readout, load, run/halt and timeout sequences.
module tb_debug_cmd_ctrl;

  localparam logic [5:0] CStart = 6'b000001, CReset = 6'b000010, CReq = 6'b000011;
  localparam logic [5:0] CLsb = 6'b000100, CMsb = 6'b000101, CGet = 6'b001000;
  localparam logic [5:0] CCont = 6'b001001, CStepM = 6'b001010, CStep = 6'b100000;
  localparam logic [5:0] CGot = 6'b100100, CGib = 6'b100101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] frame;
  logic [31:0] o_frame_to_blaze;
  logic        o_frame_valid, o_pipe_enable, o_pipe_reset, i_halt, o_instr_we;
  logic [8:0]  o_instr_addr;
  logic [31:0] o_instr_data;
  logic        o_rd_req;
  logic [5:0]  o_rd_sel;
  logic [15:0] o_rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        resp_en;

  int n_chk, n_err;
  int pe_cyc, pe_rise, pr_cyc, we_cyc, fv_cyc, req_n, rsp_k;
  logic        pe_prev;
  logic [8:0]  we_addr;
  logic [31:0] we_data;
  logic [5:0]  req_sel [16];
  logic [15:0] req_addr [16];

  typedef struct {
    logic [5:0]  code;
    logic [8:0]  at;
    logic [15:0] ad;
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } vec_t;
  vec_t tv [9];

  always #5 clk = ~clk;

  debug_cmd_ctrl dut (
    .i_clock           (clk),
    .i_reset           (rst_n),
    .i_frame_from_blaze(frame),
    .o_frame_to_blaze  (o_frame_to_blaze),
    .o_frame_valid     (o_frame_valid),
    .o_pipe_enable     (o_pipe_enable),
    .o_pipe_reset      (o_pipe_reset),
    .i_halt            (i_halt),
    .o_instr_we        (o_instr_we),
    .o_instr_addr      (o_instr_addr),
    .o_instr_data      (o_instr_data),
    .o_rd_req          (o_rd_req),
    .o_rd_sel          (o_rd_sel),
    .o_rd_addr         (o_rd_addr),
    .i_rd_data         (rd_data),
    .i_rd_valid        (rd_valid)
  );

  // Output monitor, sampled mid-cycle.
  initial begin
    pe_cyc = 0; pe_rise = 0; pr_cyc = 0; we_cyc = 0; fv_cyc = 0; req_n = 0;
    pe_prev = 1'b0; we_addr = '0; we_data = '0;
    forever begin
      @(negedge clk);
      if (o_pipe_enable) pe_cyc++;
      if (o_pipe_enable && !pe_prev) pe_rise++;
      pe_prev = o_pipe_enable;
      if (o_pipe_reset) pr_cyc++;
      if (o_instr_we) begin we_cyc++; we_addr = o_instr_addr; we_data = o_instr_data; end
      if (o_frame_valid) fv_cyc++;
      if (o_rd_req && req_n < 16) begin
        req_sel[req_n] = o_rd_sel; req_addr[req_n] = o_rd_addr; req_n++;
      end
    end
  end

  // Readout responder: i_rd_valid two cycles after each request, data 0x11, 0x22, 0x33...
  initial begin
    rd_valid = 1'b0; rd_data = '0; rsp_k = 0;
    forever begin
      @(negedge clk);
      if (o_rd_req && resp_en) begin
        repeat (2) @(posedge clk);
        #1; rd_valid = 1'b1; rd_data = 32'h11 * (rsp_k + 1);
        @(posedge clk);
        #1; rd_valid = 1'b0; rd_data = '0; rsp_k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [5:0] code, input logic [8:0] at, input logic [15:0] ad,
                      input int hold);
    frame = {code, 1'b1, at, ad};
    repeat (hold) tick();
    frame = {code, 1'b0, at, ad};
    tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input logic [31:0] mask);
    n_chk++;
    if ((act & mask) !== (exp & mask)) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h (mask %08h)", name, act, exp, mask);
    end
  endtask

  task automatic wait_fv(input string name);
    int i;
    for (i = 0; i < 30 && !o_frame_valid; i++) tick();
    if (!o_frame_valid) begin
      n_chk++; n_err++;
      $display("FAIL %s: o_frame_valid got 0 want 1 within 30 cycles", name);
    end
  endtask

  function automatic logic [31:0] st(input logic [5:0] c, input logic e, input logic h,
                                     input logic r, input logic m, input logic [15:0] n);
    return {c, e, h, r, m, 6'b0, n};
  endfunction

  function automatic vec_t mk(input logic [5:0] c, input logic [8:0] at, input logic [15:0] ad,
                              input logic [31:0] exp, input logic [31:0] mask, input string nm);
    vec_t v;
    v.code = c; v.at = at; v.ad = ad; v.exp = exp; v.mask = mask; v.name = nm;
    return v;
  endfunction

  initial begin
    int base, pr0, pe0, pr1, we0, fv0, req0;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; frame = '0; i_halt = 1'b0; resp_en = 1'b0;

    // Running bit masked while in STEP_WAIT; code masked on rejected frames.
    tv[0] = mk(CStepM, 9'h0,   16'h0, st(CStepM, 0, 0, 0, 1, 0), 32'hFFFF_FFFF, "mode_step");
    tv[1] = mk(CStart, 9'h0,   16'h0, st(CStart, 0, 0, 0, 1, 0), 32'hFF7F_FFFF, "start_step");
    tv[2] = mk(CStep,  9'h0,   16'h0, st(CStep,  0, 0, 0, 1, 1), 32'hFF7F_FFFF, "step1");
    tv[3] = mk(CStep,  9'h0,   16'h0, st(CStep,  0, 0, 0, 1, 2), 32'hFF7F_FFFF, "step2");
    tv[4] = mk(CStep,  9'h0,   16'h0, st(CStep,  0, 0, 0, 1, 3), 32'hFF7F_FFFF, "step3");
    tv[5] = mk(CGet,   9'h0,   16'h0, st(CGet,   0, 0, 0, 1, 3), 32'hFF7F_FFFF, "mode_get");
    tv[6] = mk(CReq,   9'h003, 16'h0, st(6'h0,   1, 0, 0, 1, 3), 32'h037F_FFFF, "req_bad_at");
    tv[7] = mk(CCont,  9'h0,   16'h0, st(6'h0,   1, 0, 0, 1, 3), 32'h037F_FFFF, "cont_illegal");
    tv[8] = mk(CReset, 9'h0,   16'h0, st(CReset, 0, 0, 0, 1, 0), 32'hFFFF_FFFF, "reset_keep_mode");

    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    chk("reset_status", o_frame_to_blaze, 32'h0, 32'hFFFF_FFFF);
    chk("reset_ctrl", {27'b0, o_frame_valid, o_pipe_enable, o_pipe_reset, o_instr_we, o_rd_req},
        32'h0, 32'hFFFF_FFFF);
    chk("reset_rd", {10'b0, o_rd_sel, o_rd_addr}, 32'h0, 32'hFFFF_FFFF);
    chk("reset_instr", {23'b0, o_instr_addr} | o_instr_data, 32'h0, 32'hFFFF_FFFF);

    pe0 = pe_cyc; base = pe_rise; pr0 = pr_cyc;
    for (int i = 0; i < 9; i++) begin
      send(tv[i].code, tv[i].at, tv[i].ad, 2);
      chk(tv[i].name, o_frame_to_blaze, tv[i].exp, tv[i].mask);
    end
    chk("step_pe_cycles", pe_cyc - pe0, 3, 32'hFFFF_FFFF);
    chk("step_pe_pulses", pe_rise - base, 3, 32'hFFFF_FFFF);
    chk("table_reset_pulse", pr_cyc - pr0, 1, 32'hFFFF_FFFF);

    // Instruction memory load.
    we0 = we_cyc;
    send(CLsb, 9'h0, 16'h1234, 2);
    send(CMsb, 9'd5, 16'hABCD, 2);
    tick();
    chk("instr_we_count", we_cyc - we0, 1, 32'hFFFF_FFFF);
    chk("instr_addr", {23'b0, we_addr}, 32'd5, 32'hFFFF_FFFF);
    chk("instr_data", we_data, 32'hABCD_1234, 32'hFFFF_FFFF);

    // Three-word latch readout.
    resp_en = 1'b1;
    req0 = req_n;
    send(CReq, 9'h010, 16'h0, 2);
    for (int w = 0; w < 3; w++) begin
      wait_fv("rd_wait_word");
      chk("rd_word", o_frame_to_blaze, 32'h11 * (w + 1), 32'hFFFF_FFFF);
      chk("rd_sel", {26'b0, req_sel[req0 + w]}, 32'h26, 32'hFFFF_FFFF);
      chk("rd_addr", {16'b0, req_addr[req0 + w]}, w, 32'hFFFF_FFFF);
      send(CGot, 9'h0, 16'h0, 2);
      chk("got_drops_fv", {31'b0, o_frame_valid}, 32'h0, 32'hFFFF_FFFF);
      if (w < 2) send(CGib, 9'h0, 16'h0, 2);
    end
    send(CGib, 9'h0, 16'h0, 2);
    chk("gib4_err", o_frame_to_blaze, st(CGib, 1, 0, 0, 1, 0), 32'hFF80_0000);
    chk("rd_req_count", req_n - req0, 3, 32'hFFFF_FFFF);
    resp_en = 1'b0;

    // Continuous run, illegal REQ_DATA while running, then halt.
    send(CReset, 9'h0, 16'h0, 2);
    send(CCont, 9'h0, 16'h0, 2);
    send(CStart, 9'h0, 16'h0, 2);
    chk("run_pe", {31'b0, o_pipe_enable}, 32'h1, 32'hFFFF_FFFF);
    chk("run_status", o_frame_to_blaze, st(CStart, 0, 0, 1, 0, 0), 32'hFFC0_0000);
    req0 = req_n;
    send(CReq, 9'h001, 16'h0, 2);
    chk("run_req_err", o_frame_to_blaze, st(CReq, 1, 0, 1, 0, 0), 32'hFFC0_0000);
    chk("run_req_pe", {31'b0, o_pipe_enable}, 32'h1, 32'hFFFF_FFFF);
    chk("run_req_no_rd", req_n - req0, 0, 32'hFFFF_FFFF);
    i_halt = 1'b1;
    tick();
    i_halt = 1'b0;
    chk("halt_pe", {31'b0, o_pipe_enable}, 32'h0, 32'hFFFF_FFFF);
    chk("halt_status", o_frame_to_blaze, st(CReq, 1, 1, 0, 0, 0), 32'h03C0_0000);
    repeat (3) tick();
    chk("halt_stays", {31'b0, o_pipe_enable}, 32'h0, 32'hFFFF_FFFF);

    // Readout with no i_rd_valid: times out back to IDLE.
    pr1 = pr_cyc;
    send(CReset, 9'h0, 16'h0, 2);
    chk("reset_from_halt", o_frame_to_blaze, st(CReset, 0, 0, 0, 0, 0), 32'hFFFF_FFFF);
    chk("reset_pulse", pr_cyc - pr1, 1, 32'hFFFF_FFFF);
    fv0 = fv_cyc; req0 = req_n;
    send(CReq, 9'h001, 16'h0040, 2);
    chk("tmo_sel", {26'b0, req_sel[req0]}, 32'h20, 32'hFFFF_FFFF);
    chk("tmo_addr", {16'b0, req_addr[req0]}, 32'h40, 32'hFFFF_FFFF);
    repeat (7) tick();
    chk("tmo_not_yet", o_frame_to_blaze, 32'h0, 32'h0200_0000);
    repeat (10) tick();
    chk("tmo_err", o_frame_to_blaze, st(CReq, 1, 0, 0, 0, 0), 32'hFF80_0000);
    chk("tmo_no_fv", fv_cyc - fv0, 0, 32'hFFFF_FFFF);

    // RESET while waiting for readout data.
    req0 = req_n; pr1 = pr_cyc;
    send(CReq, 9'h002, 16'h0007, 2);
    send(CReset, 9'h0, 16'h0, 2);
    chk("rst_rdwait_pulse", pr_cyc - pr1, 1, 32'hFFFF_FFFF);
    chk("rst_rdwait_status", o_frame_to_blaze, st(CReset, 0, 0, 0, 0, 0), 32'hFFFF_FFFF);
    repeat (20) tick();
    chk("rst_rdwait_no_tmo", o_frame_to_blaze, 32'h0, 32'h0200_0000);
    chk("rst_rdwait_req", req_n - req0, 1, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/debug_cmd_ctrl.md
Name: debug_cmd_ctrl

Overview:
- Command sequencer between the MicroBlaze control-frame link and the MIPS pipeline.
- Decodes 32-bit frames {code[31:26], valid[25], addr_type[24:16], address[15:0]}.
- Runs or single-steps the pipeline, soft-resets it, and loads instruction memory.
- Serialises readout of memories, register file and inter-stage latches back to the MicroBlaze as 32-bit words, using a GOT_DATA/GIB_DATA handshake.

Parameters:
NB_CONTROL_FRAME, 32, frame width both directions
NB_INSTR_ADDR, 9, instruction memory address width
NB_ADDR_DATA, 16, frame address/data field width
NB_SEL, 6, debug controller ID width
RD_TIMEOUT, 15, max cycles waiting for i_rd_valid

Ports:
i_clock  in  1  clock
i_reset  in  1  asynchronous active-low reset
i_frame_from_blaze  in  32  command frame
o_frame_to_blaze  out  32  status word, or data word when o_frame_valid=1
o_frame_valid  out  1  o_frame_to_blaze carries a readout word
o_pipe_enable  out  1  pipeline advance enable
o_pipe_reset  out  1  one-cycle synchronous soft reset to pipeline
i_halt  in  1  pipeline retired HALT
o_instr_we  out  1  instruction memory write strobe
o_instr_addr  out  9  write address
o_instr_data  out  32  write data
o_rd_req  out  1  readout request, single cycle
o_rd_sel  out  6  controller ID
o_rd_addr  out  16  {word index or mem/reg address}
i_rd_data  in  32  readout word
i_rd_valid  in  1  i_rd_data valid

Behaviour:
- Reset (i_reset=0, async): state IDLE, mode CONT, all outputs 0, latched LSB 0, error 0, step count 0.
- Command acceptance: only on a rising edge of frame bit 25 (valid 0->1 sampled on consecutive clocks). A frame held valid for N cycles yields exactly one action.
- Codes: START 000001, RESET 000010, REQ_DATA 000011, LOAD_INSTR_LSB 000100, LOAD_INSTR_MSB 000101, MODE_GET 001000, MODE_SET_CONT 001001, MODE_SET_STEP 001010, STEP 100000, GOT_DATA 100100, GIB_DATA 100101.
- Any other code, or a code illegal in the current state, sets the error bit and leaves the state unchanged.
- States: IDLE, RUN, STEP_WAIT, HALTED, RD_REQ, RD_WAIT, RD_PRESENT, RD_ACKED.
- RESET (any state, including mid-readout): o_pipe_reset=1 for 1 cycle; go to IDLE; clear error, step count and o_frame_valid. Mode is retained.
- START in IDLE: go to RUN if mode is CONT, STEP_WAIT if mode is STEP.
- RUN: o_pipe_enable=1 every cycle.
- STEP in STEP_WAIT: o_pipe_enable=1 for exactly the next cycle; step count +1, wrapping at 16 bits.
- i_halt=1 in RUN or STEP_WAIT: go to HALTED; o_pipe_enable is 0 from the following cycle. HALTED leaves only on RESET or a readout.
- MODE_SET_*: legal in IDLE/HALTED only.
- MODE_GET: legal anywhere. Refreshes status; no state change.
- LOAD_INSTR_LSB (IDLE only): latch address field.
- LOAD_INSTR_MSB (IDLE only): on the next cycle, o_instr_we=1 for 1 cycle with o_instr_addr=addr_type[8:0] and o_instr_data={address, latched LSB}.
- REQ_DATA: legal in IDLE/STEP_WAIT/HALTED; in RUN it sets error.
  - Map addr_type to (sel, words):
    - 000000001 -> 100000,1
    - 000000010 -> 100001,1
    - 000000100 -> 000000,1
    - 000000101 -> 000001,1
    - 000001000 -> 100100,1
    - 000001001 -> 100101,2
    - 000010000 -> 100110,3
    - 000010001 -> 100111,2
    - 000100000/001 -> 101000/101001,2
    - 001000000/001 -> 101010/101011,2
    - anything else -> error.
  - Memory/register targets: o_rd_addr=address. Latch targets: o_rd_addr=word index, starting at 0.
  - Sequence: RD_REQ (o_rd_req pulse) -> RD_WAIT -> on i_rd_valid capture the word -> RD_PRESENT (o_frame_valid=1, o_frame_to_blaze=word).
- GOT_DATA in RD_PRESENT: drop o_frame_valid, go to RD_ACKED.
- GIB_DATA in RD_ACKED:
  - If index+1 < words: increment index and go to RD_REQ.
  - Otherwise set error and return to the saved origin state.
- Any other legal command in RD_ACKED ends the readout (return to origin), then executes.
- RD_WAIT timeout after RD_TIMEOUT cycles: set error, o_frame_valid stays 0, return to origin.
- Status word when o_frame_valid=0: [31:26] last accepted code, [25] error, [24] halted, [23] running, [22] mode (1=STEP), [21:16] 0, [15:0] step count or cycle count.

Optional Feature:
- CYCLE_COUNT_EN defined: 32-bit counter increments on every o_pipe_enable cycle and clears on RESET. Status [15:0] shows its low 16 bits. REQ_DATA with addr_type 000000110 returns the full 32-bit value, 1 word, without an o_rd_req.
- Undefined: no counter. Status [15:0] shows step count; addr_type 000000110 sets error.

Test Plan:
- Reset released, no frames -> all outputs 0, status 0x00000000, mode CONT.
- MODE_SET_STEP, START, STEP x3, each frame held valid 2 cycles -> exactly 3 single-cycle o_pipe_enable pulses, status[15:0]=3, status[22]=1.
- LOAD_INSTR_LSB address=0x1234 then LOAD_INSTR_MSB addr_type=5 address=0xABCD -> one o_instr_we cycle, o_instr_addr=5, o_instr_data=0xABCD1234.
- REQ_DATA addr_type 000010000, i_rd_valid 2 cycles after each o_rd_req with data 0x11,0x22,0x33, GOT/GIB between words -> o_rd_sel=100110, o_rd_addr 0,1,2, frames 0x11,0x22,0x33. A 4th GIB sets status[25].
- START in CONT mode, REQ_DATA while running -> error set, o_pipe_enable stays 1. Then i_halt=1 -> o_pipe_enable=0 the next cycle, status[24]=1.
- REQ_DATA with i_rd_valid never asserted -> error set after 15 cycles. RESET during RD_WAIT -> o_pipe_reset pulse, IDLE, error cleared.
